handover_ctrl: RTL and testbench
================================

HANDOVER_CTRL -- requirements
Module: handover_ctrl

Interface
REQ-001 Parameter HYST, default 8'd10: margin by which a candidate quality must exceed the serving quality.
REQ-002 Parameter DWELL, default 3: consecutive cycles the margin must hold before a handover starts.
REQ-003 Parameter ACK_TIMEOUT, default 8: cycles to wait for a target acknowledge.
REQ-004 Parameter FIFO_DEPTH, default 4: server words buffered during a handover.
REQ-005 clk  input  1  single clock; all state updates on the rising edge.
REQ-006 reset  input  1  asynchronous, active-high.
REQ-007 signalquality1/2/3  input  8 each  per-base-station quality, unsigned.
REQ-008 sv_valid  input  1  server word present this cycle.
REQ-009 SV_data  input  4  server word.
REQ-010 tgt_req  output  3  one-hot handover request to the target base station (bit0=BS1).
REQ-011 tgt_ack  input  3  one-hot acknowledge from the base stations.
REQ-012 serving  output  3  one-hot serving base station; drives the BSx_DM_respond selects.
REQ-013 ho_busy  output  1  high while the state is not IDLE.
REQ-014 out_valid / final_data  output  1 / 4  word delivered to the mobile device.
REQ-015 ho_fail  output  1  one-cycle pulse on acknowledge timeout.
REQ-016 ovf  output  1  sticky flag: a word was dropped; cleared only by reset.

Function
REQ-017 The FSM SHALL have states IDLE, DWELL, REQ, SWITCH and DRAIN.
REQ-018 Candidate selection:
- candidate = the non-serving station with the highest quality; ties go to the lowest index.
- candidate is valid when its quality > serving quality + HYST, computed at 9-bit width with no wrap.
REQ-019 IDLE->DWELL when a valid candidate exists and the FIFO is empty; a dwell counter loads 1.
REQ-020 In DWELL:
- the counter increments each cycle while the same candidate stays valid;
- on counter==DWELL -> REQ;
- if the candidate changes or becomes invalid -> IDLE.
REQ-021 In REQ:
- tgt_req is driven one-hot to the candidate;
- on tgt_ack matching the candidate -> SWITCH;
- after ACK_TIMEOUT cycles without a matching ack -> IDLE, ho_fail pulses and serving is unchanged.
- a non-matching ack bit is ignored.
REQ-022 SWITCH lasts exactly one cycle: serving <= candidate, tgt_req <= 0, then -> DRAIN.
REQ-023 In DRAIN the FSM pops one FIFO word per cycle to out_valid/final_data and returns to IDLE when the FIFO is empty.
REQ-024 In IDLE and DWELL with the FIFO empty, sv_valid/SV_data SHALL appear on out_valid/final_data exactly 1 cycle later (registered).
REQ-025 In REQ, SWITCH and DRAIN, sv_valid words SHALL be pushed to the FIFO and out_valid carries only FIFO pops, so delivery order is preserved.
REQ-026 A simultaneous push and pop in DRAIN SHALL both occur; occupancy stays unchanged.
REQ-027 A push while the FIFO is full with no pop SHALL drop the word and set ovf.
REQ-028 No new DWELL SHALL start while the FIFO is non-empty.
REQ-029 The DWELL and REQ counters SHALL saturate and never wrap.

Reset
REQ-030 On reset assertion, asynchronously:
- state = IDLE, serving = 3'b001, tgt_req = 0;
- out_valid = 0, final_data = 0, ho_busy = 0, ho_fail = 0, ovf = 0;
- FIFO emptied; counters = 0.
REQ-031 Reset asserted mid-handover SHALL abandon the handover: no ack is honoured and buffered words are discarded.
REQ-032 The first rising edge after reset deassertion SHALL operate normally.

Structure
REQ-033 Package ho_pkg SHALL hold:
- the state enum;
- the one-hot station constants BS1=3'b001, BS2=3'b010, BS3=3'b100;
- the default parameter values.
REQ-034 The buffer SHALL be a sub-module ho_fifo (parameterised depth and width 4, push, pop, full, empty); everything else is in handover_ctrl.

Verification
REQ-035 Quality 70/30/20 with serving BS1, SV_data 2,5,7 on consecutive cycles -> final_data 2,5,7 each one cycle later; tgt_req stays 0.
REQ-036 Quality changes to 30/90/30 -> after 3 cycles tgt_req=3'b010; ack from BS2 on the 2nd REQ cycle -> serving=3'b010 one cycle later.
REQ-037 SV_data 2,3,3 sent during REQ -> out_valid=0 during REQ and SWITCH; 2,3,3 delivered in order in DRAIN; ho_busy falls after the last pop.
REQ-038 Quality 60/30/30 with serving BS2 and no ack -> after 8 cycles ho_fail pulses once and serving stays 3'b010.
REQ-039 Quality 50/60/60 with serving BS1 -> no handover (margin 10 not exceeded); then 50/61/61 -> target BS2 (tie goes to the lowest index).
REQ-040 6 words pushed during a held-off REQ -> first 4 delivered, ovf=1; reset asserted mid-REQ -> all outputs at reset values asynchronously.

Source files
------------

// File: rtl/ho_pkg.sv
// Shared types and constants for the handover controller.
package ho_pkg;

   // Controller states
   typedef enum logic [2:0] {
      ST_IDLE,
      ST_DWELL,
      ST_REQ,
      ST_SWITCH,
      ST_DRAIN
   } ho_state_t;

   // One-hot base station identifiers (bit0 = BS1)
   localparam logic [2:0] BS1 = 3'b001;
   localparam logic [2:0] BS2 = 3'b010;
   localparam logic [2:0] BS3 = 3'b100;

   // Default parameter values
   localparam logic [7:0] DEF_HYST        = 8'd10;
   localparam int         DEF_DWELL       = 3;
   localparam int         DEF_ACK_TIMEOUT = 8;
   localparam int         DEF_FIFO_DEPTH  = 4;

   // Datapath and counter widths
   localparam int              DATA_W  = 4;
   localparam int              CNT_W   = 8;
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   // Saturating increment so the dwell and ack timers never wrap
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == CNT_MAX) ? v : v + 8'd1;
   endfunction

endpackage

// File: rtl/ho_fifo.sv
// Small synchronous FIFO that holds server words while a handover is in flight.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module ho_fifo
   import ho_pkg::*;
#(
   parameter int DEPTH = DEF_FIFO_DEPTH,
   parameter int WIDTH = DATA_W
)(
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty,
   output logic             one_left
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;
   logic [CW-1:0]    count;
   logic             do_push;
   logic             do_pop;

   assign empty    = (count == '0);
   assign full     = (count == CW'(DEPTH));
   assign one_left = (count == CW'(1));
   assign do_pop   = pop && !empty;
   assign do_push  = push && (!full || do_pop);
   assign dout     = mem[rd_ptr];

   // Storage array; contents need no reset because count gates every read
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= din;
      end
   end

   // Pointer and occupancy bookkeeping
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
         end
         if (do_pop) begin
            rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
         end
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/handover_ctrl.sv
// Handover controller: picks a better base station with hysteresis and dwell,
// negotiates the switch with the target, and keeps server words in order
// across the switch by buffering them in ho_fifo.
module handover_ctrl
   import ho_pkg::*;
#(
   parameter logic [7:0] HYST        = DEF_HYST,
   parameter int         DWELL       = DEF_DWELL,
   parameter int         ACK_TIMEOUT = DEF_ACK_TIMEOUT,
   parameter int         FIFO_DEPTH  = DEF_FIFO_DEPTH
)(
   input  logic              clk,
   input  logic              reset,
   input  logic [7:0]        signalquality1,
   input  logic [7:0]        signalquality2,
   input  logic [7:0]        signalquality3,
   input  logic              sv_valid,
   input  logic [DATA_W-1:0] SV_data,
   output logic [2:0]        tgt_req,
   input  logic [2:0]        tgt_ack,
   output logic [2:0]        serving,
   output logic              ho_busy,
   output logic              out_valid,
   output logic [DATA_W-1:0] final_data,
   output logic              ho_fail,
   output logic              ovf
);

   ho_state_t          state;
   ho_state_t          next_state;
   logic [CNT_W-1:0]   cnt;
   logic [CNT_W-1:0]   next_cnt;
   logic [2:0]         cand_reg;
   logic [2:0]         next_cand;

   logic [7:0]         serving_q;
   logic [7:0]         best_q;
   logic [2:0]         cand;
   logic               found;
   logic               cand_valid;

   logic               load_serving;
   logic               fail_now;
   logic               bypass;
   logic               push_req;
   logic               pop_req;
   logic               ovf_set;

   logic [DATA_W-1:0]  fifo_dout;
   logic               fifo_full;
   logic               fifo_empty;
   logic               fifo_one;

   // Word buffer used while the serving link is being changed
   ho_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (DATA_W)
   ) u_fifo (
      .clk      (clk),
      .reset    (reset),
      .push     (push_req),
      .pop      (pop_req),
      .din      (SV_data),
      .dout     (fifo_dout),
      .full     (fifo_full),
      .empty    (fifo_empty),
      .one_left (fifo_one)
   );

   // Best non-serving station (ties to the lowest index) and its hysteresis test
   always_comb begin
      serving_q = signalquality1;
      if (serving[1]) begin
         serving_q = signalquality2;
      end else if (serving[2]) begin
         serving_q = signalquality3;
      end
      best_q = '0;
      cand   = '0;
      found  = 1'b0;
      if (!serving[0]) begin
         cand   = BS1;
         best_q = signalquality1;
         found  = 1'b1;
      end
      if (!serving[1] && (!found || signalquality2 > best_q)) begin
         cand   = BS2;
         best_q = signalquality2;
         found  = 1'b1;
      end
      if (!serving[2] && (!found || signalquality3 > best_q)) begin
         cand   = BS3;
         best_q = signalquality3;
         found  = 1'b1;
      end
      cand_valid = found && ({1'b0, best_q} > ({1'b0, serving_q} + {1'b0, HYST}));
   end

   // Next-state logic plus the FIFO and bypass steering for each state
   always_comb begin
      next_state   = state;
      next_cnt     = cnt;
      next_cand    = cand_reg;
      load_serving = 1'b0;
      fail_now     = 1'b0;
      bypass       = 1'b0;
      push_req     = 1'b0;
      pop_req      = 1'b0;
      case (state)
         ST_IDLE: begin
            if (fifo_empty) begin
               bypass = sv_valid;
               if (cand_valid) begin
                  next_state = ST_DWELL;
                  next_cnt   = CNT_W'(1);
                  next_cand  = cand;
               end
            end else begin
               push_req = sv_valid;
               pop_req  = 1'b1;
            end
         end
         ST_DWELL: begin
            if (fifo_empty) begin
               bypass = sv_valid;
            end else begin
               push_req = sv_valid;
               pop_req  = 1'b1;
            end
            if (!cand_valid || (cand != cand_reg)) begin
               next_state = ST_IDLE;
               next_cnt   = '0;
            end else if (cnt >= CNT_W'(DWELL)) begin
               next_state = ST_REQ;
               next_cnt   = '0;
            end else begin
               next_cnt = sat_inc(cnt);
            end
         end
         ST_REQ: begin
            push_req = sv_valid;
            if ((tgt_ack & cand_reg) != 3'b000) begin
               next_state   = ST_SWITCH;
               load_serving = 1'b1;
               next_cnt     = '0;
            end else if (cnt >= CNT_W'(ACK_TIMEOUT - 1)) begin
               next_state = ST_IDLE;
               fail_now   = 1'b1;
               next_cnt   = '0;
            end else begin
               next_cnt = sat_inc(cnt);
            end
         end
         ST_SWITCH: begin
            push_req   = sv_valid;
            next_state = ST_DRAIN;
         end
         ST_DRAIN: begin
            push_req = sv_valid;
            pop_req  = !fifo_empty;
            if (!sv_valid && (fifo_empty || fifo_one)) begin
               next_state = ST_IDLE;
            end
         end
         default: begin
            next_state = ST_IDLE;
            next_cnt   = '0;
         end
      endcase
   end

   assign ovf_set = push_req && fifo_full && !pop_req;
   assign tgt_req = (state == ST_REQ) ? cand_reg : 3'b000;
   assign ho_busy = (state != ST_IDLE);

   // FSM state, shared dwell/ack timer and the latched candidate
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= ST_IDLE;
         cnt      <= '0;
         cand_reg <= '0;
      end else begin
         state    <= next_state;
         cnt      <= next_cnt;
         cand_reg <= next_cand;
      end
   end

   // Serving station, failure pulse and sticky overflow flag
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         serving <= BS1;
         ho_fail <= 1'b0;
         ovf     <= 1'b0;
      end else begin
         if (load_serving) begin
            serving <= cand_reg;
         end
         ho_fail <= fail_now;
         if (ovf_set) begin
            ovf <= 1'b1;
         end
      end
   end

   // Registered delivery to the mobile: either the bypassed word or a FIFO pop
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         out_valid  <= 1'b0;
         final_data <= '0;
      end else begin
         out_valid <= bypass | pop_req;
         if (pop_req) begin
            final_data <= fifo_dout;
         end else if (bypass) begin
            final_data <= SV_data;
         end
      end
   end

endmodule

// File: tb/tb_handover_ctrl.sv
// Directed self-checking bench for handover_ctrl.
module tb_handover_ctrl;

   logic       clk;
   logic       reset;
   logic [7:0] signalquality1;
   logic [7:0] signalquality2;
   logic [7:0] signalquality3;
   logic       sv_valid;
   logic [3:0] SV_data;
   logic [2:0] tgt_req;
   logic [2:0] tgt_ack;
   logic [2:0] serving;
   logic       ho_busy;
   logic       out_valid;
   logic [3:0] final_data;
   logic       ho_fail;
   logic       ovf;

   int checks;
   int errors;

   handover_ctrl dut (
      .clk            (clk),
      .reset          (reset),
      .signalquality1 (signalquality1),
      .signalquality2 (signalquality2),
      .signalquality3 (signalquality3),
      .sv_valid       (sv_valid),
      .SV_data        (SV_data),
      .tgt_req        (tgt_req),
      .tgt_ack        (tgt_ack),
      .serving        (serving),
      .ho_busy        (ho_busy),
      .out_valid      (out_valid),
      .final_data     (final_data),
      .ho_fail        (ho_fail),
      .ovf            (ovf)
   );

   // Free-running clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Hard time limit so the run always ends
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   // Advance one clock and land 1 time unit after the rising edge
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_q(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
      signalquality1 = a;
      signalquality2 = b;
      signalquality3 = c;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      step();
      step();
      checks++; if (serving !== 3'b001) begin errors++; $display("[TB] FAIL reset_serving: got %b expected 001", serving); end
      checks++; if (tgt_req !== 3'b000) begin errors++; $display("[TB] FAIL reset_tgt_req: got %b expected 000", tgt_req); end
      checks++; if ({out_valid, final_data, ho_busy, ho_fail, ovf} !== 8'h00) begin errors++;
         $display("[TB] FAIL reset_flags: got v=%b d=%h b=%b f=%b o=%b expected all 0", out_valid, final_data, ho_busy, ho_fail, ovf); end
      reset = 1'b0;
   endtask

   task automatic test_bypass();
      logic [3:0] words [3];
      words[0] = 4'd2; words[1] = 4'd5; words[2] = 4'd7;
      set_q(8'd70, 8'd30, 8'd20);
      for (int i = 0; i < 3; i++) begin
         sv_valid = 1'b1;
         SV_data  = words[i];
         step();
         checks++; if (out_valid !== 1'b1 || final_data !== words[i]) begin errors++;
            $display("[TB] FAIL bypass_word%0d: got v=%b d=%0d expected v=1 d=%0d", i, out_valid, final_data, words[i]); end
         checks++; if (tgt_req !== 3'b000) begin errors++; $display("[TB] FAIL bypass_tgt_req%0d: got %b expected 000", i, tgt_req); end
      end
      sv_valid = 1'b0;
      step();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL bypass_idle: got %b expected 0", out_valid); end
   endtask

   task automatic test_handover();
      set_q(8'd30, 8'd90, 8'd30);
      for (int k = 1; k <= 3; k++) begin
         step();
         checks++; if (ho_busy !== 1'b1 || tgt_req !== 3'b000) begin errors++;
            $display("[TB] FAIL dwell_cycle%0d: got busy=%b req=%b expected busy=1 req=000", k, ho_busy, tgt_req); end
      end
      step();
      checks++; if (tgt_req !== 3'b010) begin errors++; $display("[TB] FAIL req_target: got %b expected 010", tgt_req); end
      sv_valid = 1'b1; SV_data = 4'd2;
      step();
      checks++; if (out_valid !== 1'b0 || tgt_req !== 3'b010) begin errors++;
         $display("[TB] FAIL req_hold: got v=%b req=%b expected v=0 req=010", out_valid, tgt_req); end
      SV_data = 4'd3; tgt_ack = 3'b010;
      step();
      checks++; if (serving !== 3'b010) begin errors++; $display("[TB] FAIL switch_serving: got %b expected 010", serving); end
      checks++; if (tgt_req !== 3'b000 || out_valid !== 1'b0) begin errors++;
         $display("[TB] FAIL switch_outputs: got req=%b v=%b expected req=000 v=0", tgt_req, out_valid); end
      tgt_ack = 3'b000; SV_data = 4'd3;
      step();
      checks++; if (out_valid !== 1'b0 || ho_busy !== 1'b1) begin errors++;
         $display("[TB] FAIL drain_start: got v=%b busy=%b expected v=0 busy=1", out_valid, ho_busy); end
      sv_valid = 1'b0;
      step();
      checks++; if (out_valid !== 1'b1 || final_data !== 4'd2 || ho_busy !== 1'b1) begin errors++;
         $display("[TB] FAIL drain_pop1: got v=%b d=%0d busy=%b expected v=1 d=2 busy=1", out_valid, final_data, ho_busy); end
      step();
      checks++; if (out_valid !== 1'b1 || final_data !== 4'd3 || ho_busy !== 1'b1) begin errors++;
         $display("[TB] FAIL drain_pop2: got v=%b d=%0d busy=%b expected v=1 d=3 busy=1", out_valid, final_data, ho_busy); end
      step();
      checks++; if (out_valid !== 1'b1 || final_data !== 4'd3 || ho_busy !== 1'b0) begin errors++;
         $display("[TB] FAIL drain_pop3: got v=%b d=%0d busy=%b expected v=1 d=3 busy=0", out_valid, final_data, ho_busy); end
      step();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL drain_done: got %b expected 0", out_valid); end
   endtask

   task automatic test_timeout();
      set_q(8'd60, 8'd30, 8'd30);
      for (int k = 1; k <= 12; k++) begin
         step();
         if (k == 4 || k == 11) begin
            checks++; if (tgt_req !== 3'b001) begin errors++; $display("[TB] FAIL timeout_req%0d: got %b expected 001", k, tgt_req); end
         end
         if (k < 12) begin
            checks++; if (ho_fail !== 1'b0) begin errors++; $display("[TB] FAIL timeout_early%0d: got %b expected 0", k, ho_fail); end
         end
      end
      checks++; if (ho_fail !== 1'b1 || serving !== 3'b010 || tgt_req !== 3'b000 || ho_busy !== 1'b0) begin errors++;
         $display("[TB] FAIL timeout_pulse: got f=%b s=%b req=%b busy=%b expected f=1 s=010 req=000 busy=0", ho_fail, serving, tgt_req, ho_busy); end
      set_q(8'd30, 8'd30, 8'd30);
      step();
      checks++; if (ho_fail !== 1'b0 || ho_busy !== 1'b0) begin errors++;
         $display("[TB] FAIL timeout_once: got f=%b busy=%b expected f=0 busy=0", ho_fail, ho_busy); end
   endtask

   task automatic test_hysteresis();
      reset = 1'b1;
      step();
      reset = 1'b0;
      set_q(8'd50, 8'd60, 8'd60);
      for (int k = 1; k <= 6; k++) begin
         step();
         checks++; if (ho_busy !== 1'b0 || tgt_req !== 3'b000) begin errors++;
            $display("[TB] FAIL hyst_hold%0d: got busy=%b req=%b expected busy=0 req=000", k, ho_busy, tgt_req); end
      end
      set_q(8'd50, 8'd61, 8'd61);
      for (int k = 1; k <= 4; k++) step();
      checks++; if (tgt_req !== 3'b010) begin errors++; $display("[TB] FAIL hyst_tie_target: got %b expected 010", tgt_req); end
   endtask

   task automatic test_overflow();
      for (int w = 1; w <= 6; w++) begin
         sv_valid = 1'b1;
         SV_data  = 4'(w);
         step();
         checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL ovf_push%0d_valid: got %b expected 0", w, out_valid); end
         if (w == 4) begin
            checks++; if (ovf !== 1'b0) begin errors++; $display("[TB] FAIL ovf_not_yet: got %b expected 0", ovf); end
         end
         if (w == 5) begin
            checks++; if (ovf !== 1'b1) begin errors++; $display("[TB] FAIL ovf_set: got %b expected 1", ovf); end
         end
      end
      sv_valid = 1'b0;
      step();
      step();
      checks++; if (ho_fail !== 1'b1) begin errors++; $display("[TB] FAIL ovf_timeout: got %b expected 1", ho_fail); end
      for (int w = 1; w <= 4; w++) begin
         step();
         checks++; if (out_valid !== 1'b1 || final_data !== 4'(w)) begin errors++;
            $display("[TB] FAIL ovf_deliver%0d: got v=%b d=%0d expected v=1 d=%0d", w, out_valid, final_data, w); end
      end
      step();
      checks++; if (out_valid !== 1'b0 || ovf !== 1'b1 || ho_busy !== 1'b1) begin errors++;
         $display("[TB] FAIL ovf_after: got v=%b o=%b busy=%b expected v=0 o=1 busy=1", out_valid, ovf, ho_busy); end
   endtask

   task automatic test_reset_mid_req();
      step();
      step();
      step();
      checks++; if (tgt_req !== 3'b010) begin errors++; $display("[TB] FAIL mid_req_target: got %b expected 010", tgt_req); end
      sv_valid = 1'b1; SV_data = 4'd9;
      step();
      step();
      sv_valid = 1'b0;
      tgt_ack  = 3'b010;
      #2;
      reset = 1'b1;
      #1;
      checks++; if (tgt_req !== 3'b000 || serving !== 3'b001) begin errors++;
         $display("[TB] FAIL async_reset_req: got req=%b s=%b expected req=000 s=001", tgt_req, serving); end
      checks++; if ({out_valid, final_data, ho_busy, ho_fail, ovf} !== 8'h00) begin errors++;
         $display("[TB] FAIL async_reset_flags: got v=%b d=%h b=%b f=%b o=%b expected all 0", out_valid, final_data, ho_busy, ho_fail, ovf); end
      tgt_ack = 3'b000;
      set_q(8'd70, 8'd30, 8'd20);
      sv_valid = 1'b1; SV_data = 4'd6;
      #1;
      reset = 1'b0;
      step();
      checks++; if (out_valid !== 1'b1 || final_data !== 4'd6 || serving !== 3'b001 || ho_busy !== 1'b0) begin errors++;
         $display("[TB] FAIL post_reset_first: got v=%b d=%0d s=%b busy=%b expected v=1 d=6 s=001 busy=0", out_valid, final_data, serving, ho_busy); end
      sv_valid = 1'b0;
      step();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL post_reset_discard: got %b expected 0", out_valid); end
   endtask

   // Test sequence
   initial begin
      checks   = 0;
      errors   = 0;
      reset    = 1'b1;
      sv_valid = 1'b0;
      SV_data  = '0;
      tgt_ack  = '0;
      set_q(8'd70, 8'd30, 8'd20);
      test_reset();
      test_bypass();
      test_handover();
      test_timeout();
      test_hysteresis();
      test_overflow();
      test_reset_mid_req();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
